// File: rtl/jt51_lfo_pkg.sv
// Shared constants and types for the JT51 LFO host register controller.
// Address defaults, busy window default and the commit FSM state type.
package jt51_lfo_pkg;

  localparam logic [7:0] LFO_ADDR_TEST    = 8'h01;
  localparam logic [7:0] LFO_ADDR_LFRQ    = 8'h18;
  localparam logic [7:0] LFO_ADDR_PAMD    = 8'h19;
  localparam logic [7:0] LFO_ADDR_CTW     = 8'h1B;
  localparam int         DEF_BUSY_CYCLES  = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_t;

endpackage

// File: rtl/jt51_lfo_ctrl_busy.sv
// CPU write-strobe edge detector and write-busy window generator.
// Produces address-write and accepted-data-write strobes plus the wr_lost pulse.
module jt51_lfo_ctrl_busy
  import jt51_lfo_pkg::*;
#(
  parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wr_n,
  input  logic i_a0,
  output logic o_addr_we,
  output logic o_accept,
  output logic o_busy,
  output logic o_wr_lost
);

  localparam logic [7:0] LP_LOAD = 8'(BUSY_CYCLES);

  logic       r_wr_n_d;
  logic [7:0] r_cnt;
  logic       r_wr_lost;
  logic       w_wr;
  logic       w_drop;

  // Previous-clock copy resets low so a strobe held low across reset is not a write.
  assign w_wr      = ~i_wr_n & r_wr_n_d;
  assign o_busy    = (r_cnt != 8'd0);
  assign o_addr_we = w_wr & ~i_a0;
  assign o_accept  = w_wr & i_a0 & ~o_busy;
  assign w_drop    = w_wr & i_a0 & o_busy;
  assign o_wr_lost = r_wr_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_n_d  <= 1'b0;
      r_cnt     <= 8'd0;
      r_wr_lost <= 1'b0;
    end else begin
      r_wr_n_d  <= i_wr_n;
      r_wr_lost <= w_drop;
      if (o_accept)
        r_cnt <= LP_LOAD;
      else if (r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/jt51_lfo_ctrl.sv
// Host-side LFO register controller: decodes CPU writes into shadow registers
// and commits them to the LFO configuration only on a sample boundary.
module jt51_lfo_ctrl
  import jt51_lfo_pkg::*;
#(
  parameter int         BUSY_CYCLES = DEF_BUSY_CYCLES,
  parameter logic [7:0] ADDR_TEST   = LFO_ADDR_TEST,
  parameter logic [7:0] ADDR_LFRQ   = LFO_ADDR_LFRQ,
  parameter logic [7:0] ADDR_PAMD   = LFO_ADDR_PAMD,
  parameter logic [7:0] ADDR_CTW    = LFO_ADDR_CTW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       zero,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       busy,
  output logic       wr_lost,
  output logic [7:0] lfo_freq,
  output logic [6:0] lfo_amd,
  output logic [6:0] lfo_pmd,
  output logic [1:0] lfo_w,
  output logic [1:0] ct,
  output logic       lfo_rst
);

  logic          w_addr_we;
  logic          w_accept;
  logic          w_lfo_addr;
  logic          w_lfo_wr;
  logic          w_commit;
  commit_state_t r_state;
  commit_state_t w_state_next;

  logic [7:0] r_addr;
  logic       r_dirty;
  logic       r_rst_s;
  logic [7:0] r_freq_s;
  logic [6:0] r_amd_s;
  logic [6:0] r_pmd_s;
  logic [1:0] r_ct_s;
  logic [1:0] r_w_s;

  logic       r_lfo_rst;
  logic [7:0] r_lfo_freq;
  logic [6:0] r_lfo_amd;
  logic [6:0] r_lfo_pmd;
  logic [1:0] r_lfo_w;
  logic [1:0] r_ct;

  jt51_lfo_ctrl_busy #(
    .BUSY_CYCLES (BUSY_CYCLES)
  ) u_busy (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_n    (wr_n),
    .i_a0      (a0),
    .o_addr_we (w_addr_we),
    .o_accept  (w_accept),
    .o_busy    (busy),
    .o_wr_lost (wr_lost)
  );

  assign w_lfo_addr = (r_addr == ADDR_TEST) || (r_addr == ADDR_LFRQ) ||
                      (r_addr == ADDR_PAMD) || (r_addr == ADDR_CTW);
  assign w_lfo_wr   = w_accept & w_lfo_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // A write landing on the commit edge keeps the FSM pending for the next boundary.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_lfo_wr) w_state_next = ST_PEND;
      ST_PEND: if (zero && !w_lfo_wr) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_commit = 1'b0;
    if (r_state == ST_PEND)
      w_commit = zero & r_dirty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= 8'd0;
      r_dirty  <= 1'b0;
      r_rst_s  <= 1'b0;
      r_freq_s <= 8'd0;
      r_amd_s  <= 7'd0;
      r_pmd_s  <= 7'd0;
      r_ct_s   <= 2'd0;
      r_w_s    <= 2'd0;
    end else begin
      if (w_addr_we)
        r_addr <= din;
      if (w_lfo_wr)
        r_dirty <= 1'b1;
      else if (w_commit)
        r_dirty <= 1'b0;
      if (w_accept) begin
        if (r_addr == ADDR_TEST) begin
          r_rst_s <= din[1];
        end else if (r_addr == ADDR_LFRQ) begin
          r_freq_s <= din;
        end else if (r_addr == ADDR_PAMD) begin
          if (din[7]) r_pmd_s <= din[6:0];
          else        r_amd_s <= din[6:0];
        end else if (r_addr == ADDR_CTW) begin
          r_ct_s <= din[7:6];
          r_w_s  <= din[1:0];
        end
      end
    end
  end

  // Outputs copy the shadows as they stood before any write on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfo_rst  <= 1'b0;
      r_lfo_freq <= 8'd0;
      r_lfo_amd  <= 7'd0;
      r_lfo_pmd  <= 7'd0;
      r_lfo_w    <= 2'd0;
      r_ct       <= 2'd0;
    end else if (w_commit) begin
      r_lfo_rst  <= r_rst_s;
      r_lfo_freq <= r_freq_s;
      r_lfo_amd  <= r_amd_s;
      r_lfo_pmd  <= r_pmd_s;
      r_lfo_w    <= r_w_s;
      r_ct       <= r_ct_s;
    end
  end

  assign lfo_rst  = r_lfo_rst;
  assign lfo_freq = r_lfo_freq;
  assign lfo_amd  = r_lfo_amd;
  assign lfo_pmd  = r_lfo_pmd;
  assign lfo_w    = r_lfo_w;
  assign ct       = r_ct;

endmodule

// File: tb/tb_jt51_lfo_ctrl.sv
// Self-checking bench for jt51_lfo_ctrl: directed scenarios plus random CPU
// traffic compared every clock against a transaction-level reference model.
module tb_jt51_lfo_ctrl;

  localparam int BUSY = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       zero = 1'b0;
  logic       wr_n = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'd0;
  logic       busy, wr_lost, lfo_rst;
  logic [7:0] lfo_freq;
  logic [6:0] lfo_amd, lfo_pmd;
  logic [1:0] lfo_w, ct;

  jt51_lfo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .zero(zero), .wr_n(wr_n), .a0(a0), .din(din),
    .busy(busy), .wr_lost(wr_lost), .lfo_freq(lfo_freq), .lfo_amd(lfo_amd),
    .lfo_pmd(lfo_pmd), .lfo_w(lfo_w), .ct(ct), .lfo_rst(lfo_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int freq; int amd; int pmd; int w; int ct; int rst;
  } cfg_t;

  cfg_t m_shadow, m_out;
  bit   m_pend, m_have_acc, m_prev_wr_n, m_lost;
  int   m_edge, m_acc_edge, m_addr;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_shadow = '{0, 0, 0, 0, 0, 0};
    m_out = '{0, 0, 0, 0, 0, 0};
    m_pend = 0; m_have_acc = 0; m_prev_wr_n = 0; m_lost = 0;
    m_edge = 0; m_acc_edge = 0; m_addr = 0;
  endfunction

  function automatic bit model_busy_after(int k);
    return m_have_acc && ((k - m_acc_edge) < BUSY);
  endfunction

  // One rising edge of the reference model, using the inputs the DUT sampled.
  function automatic void model_edge();
    bit wr, busy_before, lfo_wr;
    int d;
    wr = !wr_n && m_prev_wr_n;
    m_edge++;
    busy_before = model_busy_after(m_edge - 1);
    m_lost = 0;
    lfo_wr = 0;
    d = int'(din);
    if (m_pend && zero) m_out = m_shadow;
    if (wr) begin
      if (!a0) begin
        m_addr = d;
        $display("addr write 0x%02h", d);
      end else if (busy_before) begin
        m_lost = 1;
        $display("data write addr=0x%02h data=0x%02h dropped", m_addr, d);
      end else begin
        m_have_acc = 1;
        m_acc_edge = m_edge;
        case (m_addr)
          'h01: begin m_shadow.rst = (d / 2) % 2; lfo_wr = 1; end
          'h18: begin m_shadow.freq = d; lfo_wr = 1; end
          'h19: begin
            if (d >= 128) m_shadow.pmd = d - 128; else m_shadow.amd = d;
            lfo_wr = 1;
          end
          'h1B: begin m_shadow.ct = d / 64; m_shadow.w = d % 4; lfo_wr = 1; end
          default: ;
        endcase
        $display("data write addr=0x%02h data=0x%02h accepted", m_addr, d);
      end
    end
    m_pend = (m_pend && !zero) || lfo_wr;
    m_prev_wr_n = wr_n;
  endfunction

  task automatic compare_all();
    check("busy", busy, model_busy_after(m_edge));
    check("wr_lost", wr_lost, m_lost);
    check("lfo_freq", lfo_freq, m_out.freq);
    check("lfo_amd", lfo_amd, m_out.amd);
    check("lfo_pmd", lfo_pmd, m_out.pmd);
    check("lfo_w", lfo_w, m_out.w);
    check("ct", ct, m_out.ct);
    check("lfo_rst", lfo_rst, m_out.rst);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    zero = 1'b0;
  endtask

  task automatic wr(input logic a0v, input logic [7:0] d);
    a0 = a0v; din = d; wr_n = 1'b0;
    tick();
    wr_n = 1'b1;
    tick();
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("busy_timeout", busy, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;
    repeat (3) tick();

    // Commit on zero, 10 clocks after the data write.
    wr(0, 8'h18);
    wr(1, 8'hA5);
    repeat (8) tick();
    check("freq_before_zero", lfo_freq, 8'h00);
    zero = 1'b1;
    tick();
    check("freq_commit", lfo_freq, 8'hA5);
    wait_busy_low();

    // AMD/PMD split into two fields, one commit.
    wr(0, 8'h19);
    wr(1, 8'h7F);
    wait_busy_low();
    wr(1, 8'hC3);
    zero = 1'b1;
    tick();
    check("amd_split", lfo_amd, 7'h7F);
    check("pmd_split", lfo_pmd, 7'h43);
    wait_busy_low();

    // Data write while busy is dropped.
    wr(0, 8'h1B);
    wr(1, 8'h02);
    a0 = 1'b1; din = 8'hC3; wr_n = 1'b0;
    tick();
    check("wr_lost_pulse", wr_lost, 1'b1);
    wr_n = 1'b1;
    tick();
    check("wr_lost_clear", wr_lost, 1'b0);
    zero = 1'b1;
    tick();
    check("w_after_drop", lfo_w, 2'd2);
    check("ct_after_drop", ct, 2'd0);
    wait_busy_low();

    // Write colliding with zero while pending.
    wr(0, 8'h18);
    wr(1, 8'h10);
    wait_busy_low();
    a0 = 1'b1; din = 8'h20; wr_n = 1'b0; zero = 1'b1;
    tick();
    wr_n = 1'b1;
    check("freq_collide_old", lfo_freq, 8'h10);
    tick();
    zero = 1'b1;
    tick();
    check("freq_collide_new", lfo_freq, 8'h20);
    wait_busy_low();

    // LFO reset level from the test register; non-LFO address only raises busy.
    wr(0, 8'h01);
    wr(1, 8'h02);
    zero = 1'b1;
    tick();
    check("lfo_rst_set", lfo_rst, 1'b1);
    wait_busy_low();
    wr(1, 8'h00);
    zero = 1'b1;
    tick();
    check("lfo_rst_clr", lfo_rst, 1'b0);
    wait_busy_low();
    wr(0, 8'h20);
    wr(1, 8'h55);
    check("busy_other_addr", busy, 1'b1);
    zero = 1'b1;
    tick();
    wait_busy_low();

    // Asynchronous reset while busy and pending.
    wr(0, 8'h18);
    wr(1, 8'h77);
    check("busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("freq_in_rst", lfo_freq, 8'h20 & 8'h00);
    #1;
    rst_n = 1'b1;
    zero = 1'b1;
    tick();
    check("no_commit_after_rst", lfo_freq, 8'h00);

    // Random CPU traffic with random sample boundaries.
    for (int i = 0; i < 4000; i++) begin
      if (wr_n) begin
        if ($urandom_range(0, 3) == 0) begin
          a0 = 1'($urandom_range(0, 1));
          if (!a0) begin
            case ($urandom_range(0, 5))
              0: din = 8'h01;
              1: din = 8'h18;
              2: din = 8'h19;
              3: din = 8'h1B;
              4: din = 8'h20;
              default: din = 8'($urandom);
            endcase
          end else begin
            din = 8'($urandom);
          end
          wr_n = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        wr_n = 1'b1;
      end
      zero = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
